// File: rtl/de4_sopc_ready_latency_source_pkg.sv
// Shared stream parameters for the DE4 SOPC ready-latency source adapter.
// These are the defaults for payload width, FIFO depth and sink ready latency.
package de4_sopc_ready_latency_source_pkg;

  localparam int ST_DATA_WIDTH    = 37;
  localparam int ST_DEPTH         = 4;
  localparam int ST_READY_LATENCY = 2;

endpackage

// File: rtl/de4_sopc_ready_latency_source_delay_line.sv
// Delays the sink ready by LATENCY clock edges so that it becomes the beat grant.
// The register chain resets to zero, so no grant appears for LATENCY cycles after reset.
module de4_sopc_ready_latency_source_delay_line
  import de4_sopc_ready_latency_source_pkg::*;
#(
  parameter int LATENCY = ST_READY_LATENCY
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ready,
  output logic grant
);

  logic [LATENCY-1:0] pipe_r;

  // shift register carrying ready credits toward the grant tap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= ready;
      for (int k = 1; k < LATENCY; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign grant = pipe_r[LATENCY-1];

endmodule

// File: rtl/de4_sopc_ready_latency_source.sv
// Avalon-ST source adapter: takes a ready-latency-0 stream and drives a sink whose ready latency is READY_LATENCY.
// A small FIFO holds words while the ready credits from the sink are still travelling through the delay line.
module de4_sopc_ready_latency_source
  import de4_sopc_ready_latency_source_pkg::*;
#(
  parameter int DATA_WIDTH    = ST_DATA_WIDTH,
  parameter int DEPTH         = ST_DEPTH,
  parameter int ADDR_WIDTH    = 2,
  parameter int READY_LATENCY = ST_READY_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [ADDR_WIDTH:0]   count_next_s;
  logic                  in_ready_r;
  logic                  grant_s;
  logic                  push_s;
  logic                  pop_s;

  de4_sopc_ready_latency_source_delay_line #(
    .LATENCY (READY_LATENCY)
  ) u_delay_line (
    .clk     (clk),
    .reset_n (reset_n),
    .ready   (out_ready),
    .grant   (grant_s)
  );

  // A grant that finds the FIFO empty is simply lost; credits are never banked.
  assign pop_s  = grant_s && (count_r != {(ADDR_WIDTH + 1){1'b0}});
  assign push_s = in_valid && in_ready_r;

  // occupancy after this edge
  always_comb begin
    count_next_s = count_r;
    if (push_s && !pop_s) begin
      count_next_s = count_r + (ADDR_WIDTH + 1)'(1);
    end else if (pop_s && !push_s) begin
      count_next_s = count_r - (ADDR_WIDTH + 1)'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // pointers, occupancy and the registered upstream ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_r  <= '0;
      rd_addr_r  <= '0;
      count_r    <= '0;
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
      end
      if (pop_s) begin
        rd_addr_r <= rd_addr_r + ADDR_WIDTH'(1);
      end
      count_r    <= count_next_s;
      in_ready_r <= (count_next_s < DEPTH_C);
    end
  end

  // payload storage, left unreset so it can map onto distributed RAM
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_addr_r] <= in_data;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = pop_s;
  assign out_data   = mem_r[rd_addr_r];
  assign fill_level = count_r;

endmodule

// File: tb/tb_de4_sopc_ready_latency_source.sv
// Bench for the ready-latency source adapter (L=2, DEPTH=4): directed phases followed by a random phase.
// The expected words are queued when an accept is predicted; a negedge monitor pops them as beats appear.
module tb_de4_sopc_ready_latency_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [36:0] out_data;
  logic [2:0]  fill_level;

  int n_checks = 0;
  int n_errors = 0;

  // reference state, kept entirely by the bench
  logic [36:0] exp_q [$];
  int          m_cnt = 0;
  logic        m_in_ready = 1'b0;
  logic [1:0]  m_pipe = 2'b00;

  de4_sopc_ready_latency_source dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance one edge and move off it before driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference update at each edge, or clear on reset
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        m_cnt      = 0;
        m_in_ready = 1'b0;
        m_pipe     = 2'b00;
      end else begin
        automatic logic pop  = m_pipe[1] && (m_cnt != 0);
        automatic logic push = in_valid && m_in_ready;
        if (push) exp_q.push_back(in_data);
        m_cnt      = m_cnt + int'(push) - int'(pop);
        m_in_ready = (m_cnt < 4);
        m_pipe     = {m_pipe[0], out_ready};
      end
    end
  end

  // monitor: every cycle compare status outputs, and pop the scoreboard on each beat
  initial begin
    forever begin
      @(negedge clk);
      begin
        automatic logic exp_valid = reset_n && m_pipe[1] && (m_cnt != 0);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("in_ready", 64'(in_ready), 64'(m_in_ready));
        check("fill_level", 64'(fill_level), 64'(m_cnt));
        if (exp_valid) begin
          if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 64'(1), 64'(0));
          end else begin
            automatic logic [36:0] w = exp_q.pop_front();
            if (out_valid) check("out_data", 64'(out_data), 64'(w));
          end
        end
      end
    end
  end

  initial begin
    automatic logic [36:0] seq = 37'h100;

    // 1: reset held with inputs active, then released
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 37'h0AA;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b0;
    check("rel_out_valid0", 64'(out_valid), 64'd0);
    step();
    check("rel_in_ready1", 64'(in_ready), 64'd1);
    check("rel_out_valid1", 64'(out_valid), 64'd0);
    step();
    check("rel_out_valid2", 64'(out_valid), 64'd0);
    repeat (3) step();

    // 2: steady ready, single word passes with one-cycle latency
    in_valid = 1'b1;
    in_data  = 37'h1;
    step();
    in_valid = 1'b0;
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_data", 64'(out_data), 64'h1);
    check("t2_fill1", 64'(fill_level), 64'd1);
    step();
    check("t2_fill0", 64'(fill_level), 64'd0);
    out_ready = 1'b0;
    repeat (3) step();

    // 3: fill to DEPTH with no ready; fifth word is refused
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_data  = 37'(i);
      step();
    end
    in_valid = 1'b0;
    check("t3_fill_full", 64'(fill_level), 64'd4);
    check("t3_in_ready", 64'(in_ready), 64'd0);

    // 4: a single ready cycle releases exactly one word, two cycles later
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_c1_valid", 64'(out_valid), 64'd0);
    step();
    check("t4_c2_valid", 64'(out_valid), 64'd1);
    check("t4_c2_data", 64'(out_data), 64'h1);
    step();
    check("t4_c3_valid", 64'(out_valid), 64'd0);
    check("t4_c3_fill", 64'(fill_level), 64'd3);
    check("t4_c3_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    repeat (3) step();
    check("t4_drained", 64'(fill_level), 64'd0);

    // 5: hold two words, then push and pop together for ten cycles
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = seq;
      seq++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = seq;
      seq++;
      step();
    end
    check("t5_fill_steady", 64'(fill_level), 64'd2);
    in_valid = 1'b0;
    repeat (4) step();
    out_ready = 1'b0;
    repeat (3) step();
    check("t5_drained", 64'(fill_level), 64'd0);

    // 6: random traffic with a reset pulse in the middle
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) reset_n = 1'b0;
      if (i == 1003) reset_n = 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = seq;
      seq++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    out_ready = 1'b0;
    repeat (3) step();
    check("t6_drained", 64'(fill_level), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
